// File: rtl/piso_shift_pkg.sv
// Shared types and constants for the PISO serial transmitter and its bit counter.
package piso_shift_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Default word length, matching the 4-stage receiving shift chain.
    localparam int DEF_WIDTH = 4;

    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-slot down-counter: loads WIDTH-1, decrements on dec, flags zero.
module piso_bit_cnt
    import piso_shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic r,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Load wins over decrement so a back-to-back reload never underflows.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: accepts a word via valid/ready and sends it MSB first.
module piso_shift_tx
    import piso_shift_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             r,
    input  logic             bit_en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] din,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             accept;
    logic             in_shift_d;

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk  (clk),
        .r    (r),
        .load (cnt_load),
        .dec  (cnt_dec),
        .zero (cnt_zero)
    );

    // Ready in IDLE, or exactly at the edge that closes the last bit slot.
    assign load_ready = r && ((state_q == ST_IDLE) ||
                              ((state_q == ST_SHIFT) && bit_en && cnt_zero));
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d  = din;
                    cnt_load = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_en) begin
                    if (!cnt_zero) begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        cnt_dec = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (accept) begin
                            shreg_d  = din;
                            cnt_load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output registers follow the next state so sout is valid the cycle after accept.
        in_shift_d   = (state_d == ST_SHIFT);
        sout_d       = in_shift_d ? shreg_d[WIDTH-1] : IDLE_LVL;
        sout_valid_d = in_shift_d;
        busy_d       = in_shift_d;
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            sout_q       <= IDLE_LVL;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench for piso_shift_tx: queued expected bits compared as the DUT shifts them out.
module tb_piso_shift_tx;

    localparam int WIDTH = 4;

    logic             clk;
    logic             r;
    logic             bit_en;
    logic             load_valid;
    logic [WIDTH-1:0] din;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    int   checks;
    int   errors;
    int   done_cnt;
    int   gap_cnt;
    int   en_div;
    bit   watch_gap;
    logic exp_q[$];
    logic [WIDTH-1:0] chain;

    piso_shift_tx #(
        .WIDTH    (WIDTH),
        .IDLE_LVL (1'b0)
    ) dut (
        .clk        (clk),
        .r          (r),
        .bit_en     (bit_en),
        .load_valid (load_valid),
        .din        (din),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // bit_en generator: high every en_div-th cycle (continuous when en_div <= 1).
    initial begin
        int phase;
        phase  = 0;
        bit_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (en_div <= 1) begin
                bit_en = 1'b1;
            end else begin
                phase  = (phase + 1 >= en_div) ? 0 : phase + 1;
                bit_en = (phase == 0);
            end
        end
    end

    // Receiving chain samples on the falling edge.
    always @(negedge clk) chain <= {chain[WIDTH-2:0], sout};

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (watch_gap && sout_valid !== 1'b1) gap_cnt++;
    end

    // Scoreboard: every valid bit must match the queue head; a slot closes when bit_en is high.
    always @(negedge clk) begin
        if (r === 1'b1 && sout_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sout_unexpected: sout_valid=1 sout=%b, required no data bit", sout);
            end else begin
                if (sout !== exp_q[0]) begin
                    errors++;
                    $display("FAIL sout_bit: sout=%b required %b", sout, exp_q[0]);
                end
                if (bit_en === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_word(input logic [WIDTH-1:0] w);
        int bound;
        bound      = 0;
        load_valid = 1'b1;
        din        = w;
        while (load_ready !== 1'b1 && bound < 100) begin
            tick();
            bound++;
        end
        checks++;
        if (bound >= 100) begin
            errors++;
            $display("FAIL load_accept: load_ready=%b required 1 within 100 cycles", load_ready);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(w[i]);
        end
        tick();
        load_valid = 1'b0;
        din        = '0;
    endtask

    task automatic wait_idle();
        int bound;
        bound = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && bound < 200) begin
            tick();
            bound++;
        end
        checks++;
        if (bound >= 200) begin
            errors++;
            $display("FAIL wait_idle: busy=%b pending_bits=%0d required idle within 200 cycles",
                     busy, exp_q.size());
        end
        tick();
    endtask

    task automatic test_reset();
        int d0;
        r          = 1'b0;
        load_valid = 1'b0;
        din        = '0;
        #12;
        checks++;
        if ({sout, sout_valid, busy, done, load_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_hold: {sout,sout_valid,busy,done,load_ready}=%b required 00000",
                     {sout, sout_valid, busy, done, load_ready});
        end
        #5 r = 1'b1;
        tick();
        checks++;
        if ({sout, sout_valid, busy, done, load_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_release: {sout,sout_valid,busy,done,load_ready}=%b required 00001",
                     {sout, sout_valid, busy, done, load_ready});
        end
        d0 = done_cnt;
        repeat (6) tick();
        checks++;
        if (done_cnt != d0 || sout_valid !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_quiet: done_pulses=%0d sout_valid=%b load_ready=%b required 0 0 1",
                     done_cnt - d0, sout_valid, load_ready);
        end
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] w;
        int d0;
        w  = 4'b1011;
        d0 = done_cnt;
        load_word(w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            checks++;
            if (sout !== w[i] || sout_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL single_bit%0d: sout=%b valid=%b busy=%b done=%b required %b 1 1 0",
                         i, sout, sout_valid, busy, done, w[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || sout_valid !== 1'b0 || busy !== 1'b0 || sout !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b valid=%b busy=%b sout=%b required 1 0 0 0",
                     done, sout_valid, busy, sout);
        end
        tick();
        checks++;
        if (done !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_after: done=%b load_ready=%b required 0 1", done, load_ready);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL single_done_count: pulses=%0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        int bound;
        d0      = done_cnt;
        gap_cnt = 0;
        load_word(4'hA);
        watch_gap = 1'b1;
        load_word(4'h5);
        bound = 0;
        while (exp_q.size() != 0 && bound < 50) begin
            tick();
            bound++;
        end
        watch_gap = 1'b0;
        wait_idle();
        checks++;
        if (gap_cnt != 0) begin
            errors++;
            $display("FAIL b2b_gap: sout_valid low cycles=%0d required 0", gap_cnt);
        end
        checks++;
        if (done_cnt - d0 != 2) begin
            errors++;
            $display("FAIL b2b_done_count: pulses=%0d required 2", done_cnt - d0);
        end
    endtask

    task automatic test_strobed();
        int n;
        logic exp_lr;
        en_div = 3;
        repeat (3) tick();
        load_word(4'hC);
        n = 1;
        while (busy === 1'b1 && n < 60) begin
            exp_lr = (bit_en === 1'b1) && (exp_q.size() == 1);
            checks++;
            if (load_ready !== exp_lr) begin
                errors++;
                $display("FAIL strobe_ready: cycle=%0d load_ready=%b required %b", n, load_ready, exp_lr);
            end
            tick();
            n++;
        end
        checks++;
        if (n < 11 || n > 13) begin
            errors++;
            $display("FAIL strobe_duration: busy cycles=%0d required 10..12", n - 1);
        end
        en_div = 1;
        wait_idle();
    endtask

    task automatic test_reset_mid_word();
        int d0;
        d0 = done_cnt;
        load_word(4'hF);
        tick();
        @(posedge clk);
        #3 r = 1'b0;
        #1;
        checks++;
        if ({sout, sout_valid, busy, done, load_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_async: {sout,sout_valid,busy,done,load_ready}=%b required 00000",
                     {sout, sout_valid, busy, done, load_ready});
        end
        exp_q.delete();
        @(posedge clk);
        #1 r = 1'b1;
        #1;
        load_word(4'h3);
        wait_idle();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL midreset_done_count: pulses=%0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_loopback();
        logic [WIDTH-1:0] w;
        int bound;
        for (int k = 0; k < 6; k++) begin
            w = WIDTH'($urandom_range(0, 15));
            load_word(w);
            bound = 0;
            while (done !== 1'b1 && bound < 50) begin
                tick();
                bound++;
            end
            checks++;
            if (bound >= 50 || chain !== w) begin
                errors++;
                $display("FAIL loopback_word%0d: chain=%b required %b", k, chain, w);
            end
            tick();
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        done_cnt   = 0;
        gap_cnt    = 0;
        watch_gap  = 1'b0;
        en_div     = 1;
        r          = 1'b0;
        load_valid = 1'b0;
        din        = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_strobed();
        test_reset_mid_word();
        test_loopback();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_bits: pending=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
